fir_stream_ctrl: RTL and testbench

Frame-level sequencer for the myFIR filter core. It accepts input samples from an upstream valid/ready stream and issues each one to the FIR as a single-cycle `inputValid` pulse. It then waits for the FIR's `outputValid` and forwards the result on a downstream valid/ready stream. It sits between the sample source (memory reader or ADC buffer) and the result sink, and replaces the ad-hoc input/increment/wait sequencing used around the FIR today.

---
 rtl/fir_ctrl_pkg.sv | 18 +
 rtl/fir_timeout_timer.sv | 26 ++
 rtl/fir_stream_ctrl.sv | 105 ++++++++++
 tb/tb_fir_stream_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and default widths for the FIR stream controller.
// The state enum is shared so the top and any debug logic agree on encodings.
package fir_ctrl_pkg;

    localparam int INPUT_W  = 16;
    localparam int OUTPUT_W = 38;
    localparam int COUNT_W  = 18;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        EMIT,
        DONE
    } fir_ctrl_state_t;

endpackage

// File: rtl/fir_timeout_timer.sv
// Saturating cycle counter with synchronous clear and enable.
// `expired` flags the enabled cycle on which the count reaches LIMIT.
module fir_timeout_timer #(
    parameter int LIMIT = 63,
    localparam int W    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != W'(LIMIT))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = enable && (count_reg == W'(LIMIT - 1));

endmodule

// File: rtl/fir_stream_ctrl.sv
// Frame sequencer around the FIR core: fetch one sample, issue it, wait for
// the result (with timeout), forward it downstream, repeat for the frame.
module fir_stream_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int InputWidth    = INPUT_W,
    parameter int OutputWidth   = OUTPUT_W,
    parameter int CountWidth    = COUNT_W,
    parameter int TimeoutCycles = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CountWidth-1:0]  sampleCount,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [InputWidth-1:0]  s_data,
    output logic                   fir_inputValid,
    output logic [InputWidth-1:0]  fir_input,
    input  logic                   fir_outputValid,
    input  logic [OutputWidth-1:0] fir_output,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [OutputWidth-1:0] m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done,
    output logic                   timeoutErr
);

    fir_ctrl_state_t state_reg, state_next;

    logic [CountWidth-1:0]  count_reg;
    logic [CountWidth-1:0]  index_reg;
    logic [InputWidth-1:0]  sample_reg;
    logic [OutputWidth-1:0] m_data_reg;
    logic                   timeout_err_reg;
    logic                   timer_expired;
    logic                   last_sample;

    // The ISSUE cycle itself is the first of the TimeoutCycles, so the timer
    // (cleared in ISSUE, counting in WAIT) fires one count earlier.
    fir_timeout_timer #(
        .LIMIT (TimeoutCycles - 1)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_reg == ISSUE),
        .enable  (state_reg == WAIT),
        .expired (timer_expired)
    );

    assign last_sample = (index_reg == count_reg - 1'b1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = (sampleCount != '0) ? FETCH : DONE;
            FETCH: if (s_valid) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (fir_outputValid) state_next = EMIT;
                else if (timer_expired) state_next = DONE;
            end
            EMIT:  if (m_ready) state_next = last_sample ? DONE : FETCH;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            index_reg       <= '0;
            sample_reg      <= '0;
            m_data_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                count_reg       <= sampleCount;
                index_reg       <= '0;
                timeout_err_reg <= 1'b0;
            end
            if (state_reg == FETCH && s_valid) sample_reg <= s_data;
            if (state_reg == WAIT) begin
                if (fir_outputValid) m_data_reg <= fir_output;
                else if (timer_expired) timeout_err_reg <= 1'b1;
            end
            if (state_reg == EMIT && m_ready) index_reg <= index_reg + 1'b1;
        end
    end

    assign s_ready        = (state_reg == FETCH);
    assign fir_inputValid = (state_reg == ISSUE);
    assign fir_input      = sample_reg;
    assign m_valid        = (state_reg == EMIT);
    assign m_data         = m_data_reg;
    assign m_last         = (state_reg == EMIT) && last_sample;
    assign busy           = (state_reg != IDLE);
    assign done           = (state_reg == DONE);
    assign timeoutErr     = timeout_err_reg;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl with a fixed-latency FIR stand-in
// producing 0x20_0000_0000 + 3*x + 1 four cycles after each issue.
module tb_fir_stream_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [17:0] sampleCount = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        fir_inputValid;
    logic [15:0] fir_input;
    logic        fir_outputValid = 1'b0;
    logic [37:0] fir_output = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [37:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        timeoutErr;

    fir_stream_ctrl #(
        .InputWidth(16), .OutputWidth(38), .CountWidth(18), .TimeoutCycles(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sampleCount(sampleCount),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fir_inputValid(fir_inputValid), .fir_input(fir_input),
        .fir_outputValid(fir_outputValid), .fir_output(fir_output),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // FIR stand-in
    bit          model_on = 1'b1;
    int          dly = 0;
    logic [15:0] cap = '0;
    int          hold_err = 0;
    always @(negedge clk) begin
        fir_outputValid = 1'b0;
        if (dly > 0) begin
            dly--;
            if (dly == 0 && model_on) begin
                fir_outputValid = 1'b1;
                fir_output = 38'h20_0000_0000 + 38'(cap) * 38'd3 + 38'd1;
                if (busy && fir_input !== cap) hold_err++;
            end
        end
        if (fir_inputValid) begin
            dly = LAT;
            cap = fir_input;
        end
    end

    // Passive monitor
    int          ivalid_cnt = 0, iv_double = 0, sready_cnt = 0, mvalid_cnt = 0, done_cnt = 0;
    int          last_iv_cyc = 0, last_mv_rise = 0, last_hs_cyc = 0, last_done_cyc = 0;
    bit          iv_prev = 1'b0, mv_prev = 1'b0;
    logic [37:0] res_data[$];
    logic        res_last[$];
    always @(negedge clk) begin
        if (fir_inputValid) begin
            ivalid_cnt++;
            last_iv_cyc = cyc;
            if (iv_prev) iv_double++;
        end
        iv_prev = fir_inputValid;
        if (s_ready) sready_cnt++;
        if (m_valid) begin
            mvalid_cnt++;
            if (!mv_prev) last_mv_rise = cyc;
        end
        mv_prev = m_valid;
        if (m_valid && m_ready) begin
            res_data.push_back(m_data);
            res_last.push_back(m_last);
            last_hs_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    logic [15:0] samples[8];
    int          ptr = 0;
    bit          adv = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (adv) begin
            ptr++;
            s_data = samples[ptr % 8];
        end
        adv = s_ready && s_valid;
    endtask

    task automatic start_frame(input int n, input bit hold);
        ptr = 0;
        adv = 1'b0;
        s_data = samples[0];
        s_valid = 1'b1;
        sampleCount = 18'(n);
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
    endtask

    // Runs until done, drops start in the DONE cycle, then steps into IDLE.
    task automatic run_to_done(input int maxc, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (!got) begin
                step();
                if (done) got = 1'b1;
            end
        end
        start = 1'b0;
        chk({tag, "_reached_done"}, 64'(got), 64'd1);
        step();
    endtask

    int r0, iv0, mv0, d0, sr0;
    bit seen;

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_ivalid", 64'(fir_inputValid), 64'd0);
        chk("rst_outs", 64'({m_valid, m_last, busy, done, timeoutErr}), 64'd0);
        chk("rst_data", 64'({fir_input, m_data}), 64'd0);

        // Three-sample frame, m_ready=1
        samples[0] = 16'h0001; samples[1] = 16'h0002; samples[2] = 16'h0003;
        r0 = res_data.size(); iv0 = ivalid_cnt; d0 = done_cnt;
        start_frame(3, 1'b0);
        run_to_done(200, "frame3");
        chk("frame3_ivalid_pulses", 64'(ivalid_cnt - iv0), 64'd3);
        chk("frame3_results", 64'(res_data.size() - r0), 64'd3);
        chk("frame3_data0", 64'(res_data[r0]), 64'h20_0000_0004);
        chk("frame3_data1", 64'(res_data[r0+1]), 64'h20_0000_0007);
        chk("frame3_data2", 64'(res_data[r0+2]), 64'h20_0000_000A);
        chk("frame3_last", 64'({res_last[r0], res_last[r0+1], res_last[r0+2]}), 64'b001);
        chk("frame3_latency", 64'(last_mv_rise - last_iv_cyc), 64'(LAT + 1));
        chk("frame3_done_after_hs", 64'(last_done_cyc - last_hs_cyc), 64'd1);
        chk("frame3_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Backpressure: 5 stalled EMIT cycles
        samples[0] = 16'h1234; samples[1] = 16'hFFFF;
        r0 = res_data.size();
        m_ready = 1'b0;
        start_frame(2, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) if (!seen) begin
            step();
            if (m_valid) seen = 1'b1;
        end
        chk("bp_mvalid_seen", 64'(seen), 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_mvalid_held", 64'(m_valid), 64'd1);
            chk("bp_mdata_held", 64'(m_data), 64'h20_0000_369D);
            chk("bp_sready_low", 64'(s_ready), 64'd0);
            step();
        end
        m_ready = 1'b1;
        run_to_done(200, "bp");
        chk("bp_results", 64'(res_data.size() - r0), 64'd2);
        chk("bp_data0", 64'(res_data[r0]), 64'h20_0000_369D);
        chk("bp_data1", 64'(res_data[r0+1]), 64'h20_0002_FFFE);
        chk("bp_last", 64'({res_last[r0], res_last[r0+1]}), 64'b01);

        // Reset mid-frame, FIR result arrives after reset
        samples[0] = 16'h0009; samples[1] = 16'h000A;
        start_frame(2, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) if (!seen) begin
            step();
            if (fir_inputValid) seen = 1'b1;
        end
        chk("mid_issue_seen", 64'(seen), 64'd1);
        step();
        mv0 = mvalid_cnt; d0 = done_cnt;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("mid_rst_flags", 64'({s_ready, fir_inputValid, m_valid, m_last, busy, done, timeoutErr}), 64'd0);
        chk("mid_rst_data", 64'({fir_input, m_data}), 64'd0);
        for (int i = 0; i < 8; i++) step();
        chk("mid_rst_no_mvalid", 64'(mvalid_cnt - mv0), 64'd0);
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);

        // Timeout: FIR never answers
        samples[0] = 16'h0042;
        model_on = 1'b0;
        mv0 = mvalid_cnt;
        start_frame(1, 1'b0);
        run_to_done(200, "tmo");
        chk("tmo_done_delay", 64'(last_done_cyc - last_iv_cyc), 64'd64);
        chk("tmo_err_set", 64'(timeoutErr), 64'd1);
        chk("tmo_no_mvalid", 64'(mvalid_cnt - mv0), 64'd0);
        step(); step(); step();
        chk("tmo_err_sticky", 64'({timeoutErr, busy}), 64'b10);
        model_on = 1'b1;
        samples[0] = 16'h0005;
        r0 = res_data.size();
        start_frame(1, 1'b0);
        chk("tmo_err_cleared", 64'(timeoutErr), 64'd0);
        run_to_done(200, "after_tmo");
        chk("after_tmo_data", 64'(res_data[r0]), 64'h20_0000_0010);
        chk("after_tmo_last", 64'(res_last[r0]), 64'd1);

        // start held high for the whole frame
        samples[0] = 16'h0007; samples[1] = 16'h0008;
        r0 = res_data.size(); iv0 = ivalid_cnt; d0 = done_cnt;
        start_frame(2, 1'b1);
        run_to_done(200, "held");
        step(); step();
        chk("held_ivalid", 64'(ivalid_cnt - iv0), 64'd2);
        chk("held_results", 64'(res_data.size() - r0), 64'd2);
        chk("held_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("held_busy", 64'(busy), 64'd0);

        // Zero-length frame
        sr0 = sready_cnt; iv0 = ivalid_cnt; d0 = done_cnt;
        sampleCount = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_done_2nd", 64'({done, busy}), 64'b11);
        step();
        chk("zero_idle", 64'({done, busy}), 64'b00);
        step();
        chk("zero_no_sready", 64'(sready_cnt - sr0), 64'd0);
        chk("zero_no_ivalid", 64'(ivalid_cnt - iv0), 64'd0);
        chk("zero_done_cnt", 64'(done_cnt - d0), 64'd1);

        chk("ivalid_single_cycle", 64'(iv_double), 64'd0);
        chk("fir_input_stable", 64'(hold_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
